// File: rtl/obj_cmd_scheduler.sv
// Round-robin arbiter sharing one serializer command channel between REQ_NUM sources.
// One word is issued per serializer frame; new grants wait until the frame completes.
module obj_cmd_scheduler #(
    parameter int REQ_NUM      = 4,
    parameter int DATA_W       = 6,
    parameter int BUSY_TIMEOUT = 4,
    parameter int CNT_W        = 16,
    localparam int ID_W        = $clog2(REQ_NUM),
    localparam int TO_W        = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REQ_NUM*DATA_W-1:0] req_data_i,
    input  logic [REQ_NUM-1:0]        req_val_i,
    output logic [REQ_NUM-1:0]        req_rdy_o,
    output logic [DATA_W-1:0]         ser_data_o,
    output logic                      ser_data_val_o,
    input  logic                      ser_busy_i,
    output logic [ID_W-1:0]           grant_id_o,
    output logic                      timeout_o,
    output logic [CNT_W-1:0]          sent_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic              grant;
    logic              to_expire;
    logic [TO_W-1:0]   to_cnt;

    // Search starts one past the last winner so a granted source goes to the back of the line.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= unsigned'(REQ_NUM); i++) begin
            idx = ID_W'((32'(rr_ptr) + i) % unsigned'(REQ_NUM));
            if (!found && req_val_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant          = (state == IDLE) && !ser_busy_i && found;
    assign ser_data_val_o = (state == ISSUE);
    assign to_expire      = (state == WAIT_BUSY) && !ser_busy_i
                            && (to_cnt == TO_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        req_rdy_o = '0;
        if (grant) begin
            req_rdy_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (ser_busy_i) begin
                    state_nxt = WAIT_DONE;
                end else if (to_expire) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!ser_busy_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_ptr     <= ID_W'(REQ_NUM - 1);
            ser_data_o <= '0;
            grant_id_o <= '0;
            to_cnt     <= '0;
            timeout_o  <= 1'b0;
            sent_cnt_o <= '0;
        end else begin
            timeout_o <= to_expire;
            if (grant) begin
                ser_data_o <= req_data_i[winner*DATA_W +: DATA_W];
                grant_id_o <= winner;
                rr_ptr     <= winner;
            end
            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if ((state == WAIT_BUSY) && !ser_busy_i) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if ((state == WAIT_BUSY) && ser_busy_i && (sent_cnt_o != '1)) begin
                sent_cnt_o <= sent_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
